sprite_blitter: RTL and testbench

- Write-side counterpart to vga_controller's frame-buffer read path.
- Copies one SPR_W x SPR_H sprite from a synchronous sprite ROM into the 400x300 SRAM frame buffer at a given screen position.
- Alternatively fills the same rectangle with a solid colour (erase mode).
- Drives the write_screen_x/write_screen_y/data_to_write[5:0]/logic_enable_write path into sram_controller and emits pixels only while the display-read window is closed.

---
 rtl/sprite_blitter.sv | 182 ++++++++++++++++++
 tb/tb_sprite_blitter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_blitter.sv
// sprite_blitter: copies a ROM sprite (or a solid fill) into the frame
// buffer, stepping its pipeline only while the write window is open.
module sprite_blitter #(
    parameter int         SPR_W       = 16,
    parameter int         SPR_H       = 16,
    parameter int         ID_W        = 2,
    parameter int         SCREEN_W    = 400,
    parameter int         SCREEN_H    = 300,
    parameter logic [5:0] TRANSPARENT = 6'b110011,
    localparam int        CW          = $clog2(SPR_W),
    localparam int        RW          = $clog2(SPR_H),
    localparam int        AW          = ID_W + RW + CW
) (
    input  logic            clk50M,
    input  logic            rst,
    input  logic            start,
    input  logic [8:0]      sprite_x,
    input  logic [8:0]      sprite_y,
    input  logic [ID_W-1:0] sprite_id,
    input  logic            erase,
    input  logic [5:0]      fill_color,
    input  logic            write_enable,
    output logic [AW-1:0]   rom_addr,
    input  logic [5:0]      rom_data,
    output logic [8:0]      mem_addr_x,
    output logic [8:0]      mem_addr_y,
    output logic [5:0]      data_out,
    output logic            enable_color,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic            adv;
    logic            accept;
    logic            finish;
    logic            last_pix;
    logic            drain_cnt;
    logic [8:0]      lat_x;
    logic [8:0]      lat_y;
    logic [ID_W-1:0] lat_id;
    logic            lat_erase;
    logic [5:0]      lat_fill;
    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [CW-1:0]   s1_col;
    logic [RW-1:0]   s1_row;
    logic [9:0]      s1_x;
    logic [9:0]      s1_y;
    logic            s1_valid;
    logic            pix_valid;
    logic            x_in;
    logic            y_in;
    logic            key_hit;

    assign adv      = write_enable;
    assign last_pix = (col == CW'(SPR_W - 1)) && (row == RW'(SPR_H - 1));
    assign x_in     = s1_x < 10'(SCREEN_W);
    assign y_in     = s1_y < 10'(SCREEN_H);
    assign key_hit  = !lat_erase && (rom_data == TRANSPARENT);

    // The ROM latches its address every clock; during a stall point it at
    // the pixel held in stage 1 so rom_data still matches that pixel.
    assign rom_addr = adv ? {lat_id, row, col} : {lat_id, s1_row, s1_col};

    assign enable_color = pix_valid & write_enable;

    // State register.
    always_ff @(posedge clk50M) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state; start is refused in the cycle done is high.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !done) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (adv && last_pix) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (adv && drain_cnt) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operation parameters held for the whole blit, plus busy/done status.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            lat_x     <= '0;
            lat_y     <= '0;
            lat_id    <= '0;
            lat_erase <= 1'b0;
            lat_fill  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= finish;
            if (accept) begin
                lat_x     <= sprite_x;
                lat_y     <= sprite_y;
                lat_id    <= sprite_id;
                lat_erase <= erase;
                lat_fill  <= fill_color;
                busy      <= 1'b1;
            end else if (finish) begin
                busy <= 1'b0;
            end
        end
    end

    // Raster counters and drain counter.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= 1'b0;
        end else if (accept) begin
            col       <= '0;
            row       <= '0;
            drain_cnt <= 1'b0;
        end else if (adv) begin
            if (state == RUN) begin
                col <= col + 1'b1;
                if (col == CW'(SPR_W - 1)) row <= row + 1'b1;
            end
            if (state == DRAIN) drain_cnt <= 1'b1;
        end
    end

    // Stage 1: screen coordinates, kept 10 bits wide for clipping.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_col   <= '0;
            s1_row   <= '0;
        end else if (adv) begin
            s1_valid <= (state == RUN);
            s1_x     <= {1'b0, lat_x} + 10'(col);
            s1_y     <= {1'b0, lat_y} + 10'(row);
            s1_col   <= col;
            s1_row   <= row;
        end
    end

    // Output stage: colour select, clipping and colour-key test.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            mem_addr_x <= '0;
            mem_addr_y <= '0;
            data_out   <= '0;
            pix_valid  <= 1'b0;
        end else if (adv) begin
            mem_addr_x <= s1_x[8:0];
            mem_addr_y <= s1_y[8:0];
            data_out   <= lat_erase ? lat_fill : rom_data;
            pix_valid  <= s1_valid && x_in && y_in && !key_hit;
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: table-driven and randomized checks of sprite_blitter
// against a rectangle-level model of the expected strobe sequence.
module tb_sprite_blitter;

    localparam logic [5:0] KEY = 6'b110011;

    logic       clk50M = 1'b0;
    logic       rst;
    logic       start;
    logic [8:0] sprite_x;
    logic [8:0] sprite_y;
    logic [1:0] sprite_id;
    logic       erase;
    logic [5:0] fill_color;
    logic       write_enable;
    logic [9:0] rom_addr;
    logic [5:0] rom_data;
    logic [8:0] mem_addr_x;
    logic [8:0] mem_addr_y;
    logic [5:0] data_out;
    logic       enable_color;
    logic       busy;
    logic       done;

    sprite_blitter dut (
        .clk50M       (clk50M),
        .rst          (rst),
        .start        (start),
        .sprite_x     (sprite_x),
        .sprite_y     (sprite_y),
        .sprite_id    (sprite_id),
        .erase        (erase),
        .fill_color   (fill_color),
        .write_enable (write_enable),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .mem_addr_x   (mem_addr_x),
        .mem_addr_y   (mem_addr_y),
        .data_out     (data_out),
        .enable_color (enable_color),
        .busy         (busy),
        .done         (done)
    );

    always #10 clk50M = ~clk50M;

    // Synchronous sprite ROM.
    logic [5:0] rom_mem [1024];
    always @(posedge clk50M) rom_data <= rom_mem[rom_addr];

    int errors = 0;
    int checks = 0;
    int bad_strobes = 0;
    int we_mode = 0;
    int we_cnt = 0;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];

    typedef struct {
        int         x;
        int         y;
        logic [1:0] id;
        bit         er;
        logic [5:0] fc;
        int         rom_mode;
        int         wmode;
        int         exp_n;
        bit         chk_lat;
    } vec_t;

    vec_t vecs[6];

    // Write window: always open, 3 on / 5 off, or random.
    initial begin
        write_enable = 1'b0;
        forever begin
            @(posedge clk50M);
            #1;
            we_cnt++;
            case (we_mode)
                0:       write_enable = 1'b1;
                1:       write_enable = (we_cnt % 8) < 3;
                default: write_enable = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Collect every strobe; flag strobes outside the window or screen.
    always @(negedge clk50M) begin
        if (enable_color) begin
            if (!write_enable || mem_addr_x >= 9'd400 || mem_addr_y >= 9'd300)
                bad_strobes++;
            got_q.push_back({mem_addr_x, mem_addr_y, data_out});
        end
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check64(input string name, input logic [63:0] act,
                           input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic void fill_rom(input int mode);
        for (int a = 0; a < 1024; a++) begin
            logic [3:0] c;
            c = 4'(a);
            case (mode)
                0: rom_mem[a] = {2'b00, c};
                1: rom_mem[a] = c[0] ? {2'b00, c} : KEY;
                default: rom_mem[a] = ($urandom_range(0, 3) == 0) ?
                                      KEY : 6'($urandom_range(0, 63));
            endcase
        end
    endfunction

    // Expected strobes: raster walk of the rectangle, clip, colour key.
    function automatic void build_exp(input int x, input int y,
                                      input logic [1:0] id, input bit er,
                                      input logic [5:0] fc);
        exp_q.delete();
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                int X;
                int Y;
                logic [5:0] p;
                X = x + c;
                Y = y + r;
                p = er ? fc : rom_mem[{id, 4'(r), 4'(c)}];
                if (X < 400 && Y < 300 && (er || p != KEY))
                    exp_q.push_back({9'(X), 9'(Y), p});
            end
        end
    endfunction

    // One blit; returns in the cycle done is observed.
    task automatic run_blit(input int x, input int y, input logic [1:0] id,
                            input bit er, input logic [5:0] fc,
                            input int exp_n, input bit chk_lat,
                            input bit noise, input string tag);
        int  cyc;
        int  advs;
        int  first;
        bit  busy_ok;
        bit  got_done;
        bit  ok;
        int  bad_i;
        build_exp(x, y, id, er, fc);
        @(posedge clk50M);
        #1;
        got_q.delete();
        sprite_x   = 9'(x);
        sprite_y   = 9'(y);
        sprite_id  = id;
        erase      = er;
        fill_color = fc;
        start      = 1'b1;
        @(posedge clk50M);
        #1;
        start      = 1'b0;
        sprite_x   = 9'($urandom);
        sprite_y   = 9'($urandom);
        sprite_id  = 2'($urandom);
        erase      = 1'($urandom);
        fill_color = 6'($urandom);
        cyc = 0;
        advs = 0;
        first = -1;
        busy_ok = 1'b1;
        got_done = 1'b0;
        while (!got_done && cyc < 5000) begin
            @(negedge clk50M);
            if (cyc == 0 && write_enable)
                check64({tag, " rom_addr0"}, 64'(rom_addr), 64'({id, 8'h00}));
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (!busy) busy_ok = 1'b0;
                if (enable_color && first < 0) first = cyc;
                start = noise && (cyc == 5 || cyc == 100);
                if (write_enable) advs++;
                cyc++;
            end
        end
        start = 1'b0;
        check64({tag, " done_seen"}, 64'(got_done), 64'd1);
        check64({tag, " adv_cycles"}, 64'(advs), 64'd258);
        check64({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check64({tag, " busy_held"}, 64'(busy_ok), 64'd1);
        if (exp_n >= 0)
            check64({tag, " strobe_count"}, 64'(got_q.size()), 64'(exp_n));
        if (chk_lat)
            check64({tag, " first_latency"}, 64'(first), 64'd2);
        ok = (got_q.size() == exp_q.size());
        bad_i = -1;
        if (ok) begin
            foreach (exp_q[i]) begin
                if (ok && got_q[i] !== exp_q[i]) begin
                    ok = 1'b0;
                    bad_i = i;
                end
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            if (bad_i < 0)
                $display("FAIL %s sequence: got %0d strobes expected %0d",
                         tag, got_q.size(), exp_q.size());
            else
                $display("FAIL %s sequence: strobe %0d got %h expected %h",
                         tag, bad_i, got_q[bad_i], exp_q[bad_i]);
        end
    endtask

    initial begin
        vecs[0] = '{10,  20,  2'd1, 1'b0, 6'd0,  0, 0, 256, 1'b1};
        vecs[1] = '{10,  20,  2'd1, 1'b0, 6'd0,  1, 0, 128, 1'b0};
        vecs[2] = '{392, 296, 2'd0, 1'b1, 6'd0,  2, 0, 32,  1'b0};
        vecs[3] = '{10,  20,  2'd1, 1'b0, 6'd0,  0, 1, 256, 1'b0};
        vecs[4] = '{500, 100, 2'd3, 1'b0, 6'd9,  2, 2, 0,   1'b0};
        vecs[5] = '{384, 284, 2'd2, 1'b0, 6'd0,  1, 2, 128, 1'b0};

        rst = 1'b1;
        start = 1'b0;
        sprite_x = '0;
        sprite_y = '0;
        sprite_id = '0;
        erase = 1'b0;
        fill_color = '0;
        fill_rom(0);
        repeat (2) @(posedge clk50M);
        @(negedge clk50M);
        check64("reset_outputs",
                64'({enable_color, busy, done, rom_addr,
                     mem_addr_x, mem_addr_y, data_out}), 64'd0);
        @(posedge clk50M);
        #1;
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            we_mode = vecs[v].wmode;
            fill_rom(vecs[v].rom_mode);
            run_blit(vecs[v].x, vecs[v].y, vecs[v].id, vecs[v].er,
                     vecs[v].fc, vecs[v].exp_n, vecs[v].chk_lat, 1'b0,
                     $sformatf("vec%0d", v));
        end

        // Stray starts during a blit, then a start the cycle after done.
        we_mode = 0;
        fill_rom(0);
        run_blit(10, 20, 2'd1, 1'b0, 6'd0, 256, 1'b0, 1'b1, "noise");
        run_blit(100, 50, 2'd2, 1'b0, 6'd0, 256, 1'b1, 1'b0, "after_done");

        // A start held only during the done cycle is dropped.
        start = 1'b1;
        @(posedge clk50M);
        #1;
        start = 1'b0;
        @(negedge clk50M);
        check64("done_one_pulse", 64'(done), 64'd0);
        check64("start_in_done_ignored", 64'(busy), 64'd0);
        repeat (3) @(negedge clk50M);
        check64("still_idle", 64'(busy), 64'd0);

        // Reset in the middle of a blit.
        begin
            int n;
            we_mode = 0;
            fill_rom(0);
            @(posedge clk50M);
            #1;
            got_q.delete();
            sprite_x = 9'd50;
            sprite_y = 9'd60;
            sprite_id = 2'd2;
            erase = 1'b0;
            start = 1'b1;
            @(posedge clk50M);
            #1;
            start = 1'b0;
            n = 0;
            while (got_q.size() < 40 && n < 1000) begin
                @(negedge clk50M);
                #1;
                n++;
            end
            check64("rst_reach_40", 64'(got_q.size()), 64'd40);
            rst = 1'b1;
            @(posedge clk50M);
            #1;
            rst = 1'b0;
            @(negedge clk50M);
            check64("rst_mid_outputs",
                    64'({enable_color, busy, done, rom_addr,
                         mem_addr_x, mem_addr_y, data_out}), 64'd0);
            repeat (4) @(negedge clk50M);
            check64("rst_no_more_strobes", 64'(got_q.size()), 64'd40);
        end
        run_blit(50, 60, 2'd2, 1'b0, 6'd0, 256, 1'b1, 1'b0, "post_rst");

        // Randomized blits near the screen edges.
        for (int k = 0; k < 6; k++) begin
            int x;
            int y;
            we_mode = $urandom_range(0, 2);
            fill_rom(2);
            x = $urandom_range(340, 511);
            y = $urandom_range(240, 330);
            run_blit(x, y, 2'($urandom), ($urandom_range(0, 3) == 0),
                     6'($urandom), -1, 1'b0, 1'b0, $sformatf("rnd%0d", k));
        end

        check64("bad_strobes", 64'(bad_strobes), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
